onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port 32-bit on-chip RAM (64K-word address space, byte enables, 1-cycle read latency) between NUM_MASTERS Avalon-MM pipelined requesters, e.g. Nios CPU data port and the step-generator command DMA.
- Issues at most one RAM access per cycle. Returns read data with readdatavalid to the master that issued the read.
- Supports a quiesce request so software can drain the RAM before a soft reset.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..4.
- ADDR_W, 16, word address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address; master i in slice i
- m_byteenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_writedata  in  NUM_MASTERS*DATA_W  per-master write data
- m_waitrequest  out  NUM_MASTERS  command not accepted this cycle
- m_readdata  out  DATA_W  read data, broadcast to all masters
- m_readdatavalid  out  NUM_MASTERS  one-hot; read data valid for master i
- quiesce  in  1  block new grants while high
- idle  out  1  no grant this cycle and no read in flight
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM, valid the cycle after the read address is presented
- stat_clr  in  1  clear grant counters (feature only)
- stat_grant_cnt  out  NUM_MASTERS*16  per-master grant counters (feature only)

Behaviour:
- Request: req[i] = m_read[i] | m_write[i]. If m_read[i] and m_write[i] are both high, the command is a write and no readdatavalid is returned.
- Grant (combinational, one-hot, at most one master):
  - No grant while quiesce=1 or reset is asserted.
  - Otherwise search starts at last_grant+1 (mod NUM_MASTERS) and grants the first requesting master.
- m_waitrequest[i] = req[i] & ~grant[i]. A master's command is accepted when it requests with waitrequest low.
- Master rules: a master must hold address, data, byte enables and request stable while waitrequest is high. The arbiter does not check this.
- RAM drive:
  - mem_chipselect = |grant. Address, byte enables and write data are muxed from the granted master.
  - mem_write = granted master's m_write.
  - With no grant: outputs are 0 and chipselect is 0.
- Registered state:
  - last_grant updates only on a grant; reset value 0, so master 1 wins the first contest.
  - rd_vld and rd_id update each cycle: rd_vld = granted read, rd_id = granted index.
- Read return: m_readdatavalid[rd_id] = rd_vld, exactly 1 cycle after acceptance. m_readdata = mem_readdata unregistered, so total read latency is 1.
- Throughput:
  - A lone requester is granted every cycle, one access per cycle.
  - With N masters all requesting, each is granted once every N cycles. No master waits more than N-1 cycles.
- Ordering: a write followed by a read of the same address on the next cycle returns the new data. A single port and one access per cycle mean no read-during-write case exists.
- quiesce: takes effect the same cycle. A read accepted in the previous cycle still returns. idle = ~|grant & ~rd_vld.
- Reset values: last_grant=0, rd_vld=0, rd_id=0, counters=0. All m_readdatavalid=0, idle=1 once requests are low. Asserting reset mid-read discards the pending readdatavalid.

Optional Feature:
- ONCHIP_ARB_STATS_EN defined:
  - Per-master 16-bit grant counters, each +1 on every grant to that master.
  - Counters saturate at 0xFFFF.
  - stat_clr zeroes all counters synchronously; stat_clr wins over a simultaneous increment.
- Not defined: stat_grant_cnt is driven 0, stat_clr is ignored, and no counter registers exist. The port list is unchanged in both builds.

Decomposition:
- Package onchip_arb_pkg holds:
  - constants MAX_MASTERS=4 and STAT_W=16;
  - function rr_pick(req, last), returning a one-hot grant;
  - the index-width function clog2.
- One sub-module: onchip_arb_rr_grant, the combinational round-robin picker (req, last_grant, enable → one-hot grant, index). Muxing and registers stay in the top level.

Test Plan:
- Lone master 0 writes 0xDEADBEEF to address 0x0010 (be=0xF), then reads 0x0010 the next cycle → waitrequest stays 0; readdatavalid[0] is high 1 cycle after the read; readdata=0xDEADBEEF.
- Masters 0 and 1 both hold continuous reads after reset → grants go 1,0,1,0…; each waitrequest is high on alternate cycles; readdatavalid follows the same interleave, 1 cycle late.
- Byte-enable write: 0x11223344 to 0x0020, then be=0x2 with data 0x0000AA00, then read → 0x1122AA44.
- Read accepted at cycle t, quiesce raised at t+1 → readdatavalid still arrives at t+1; no further grants; idle=1 from t+2; drop quiesce → grants resume.
- reset_n asserted in the cycle after a read is accepted → no readdatavalid is produced; after release, last_grant=0 and the first contest with both masters requesting goes to master 1.
- With ONCHIP_ARB_STATS_EN: 5 grants to master 0 and 3 to master 1 → counters read 5 and 3. stat_clr together with a grant → counter reads 0. Forcing 0xFFFF then granting → counter stays at 0xFFFF.

Source files
------------

// File: rtl/onchip_arb_pkg.sv
// rtl/onchip_arb_pkg.sv - shared constants and round-robin helpers for onchip_mem_arbiter
package onchip_arb_pkg;

   localparam int MAX_MASTERS = 4;
   localparam int STAT_W      = 16;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

   // Scan starts one past the previous winner, so the last winner is checked last.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(
      input logic [MAX_MASTERS-1:0] req,
      input logic [1:0]             last,
      input int                     n
   );
      logic [MAX_MASTERS-1:0] grant;
      logic                   found;
      int                     idx;
      grant = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_MASTERS; k++) begin
         idx = (int'(last) + k) % n;
         if ((k <= n) && !found && req[idx[1:0]]) begin
            grant[idx[1:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/onchip_arb_rr_grant.sv
// rtl/onchip_arb_rr_grant.sv - combinational round-robin picker (one-hot grant plus index)
module onchip_arb_rr_grant
   import onchip_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   input  logic             enable_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   logic [MAX_MASTERS-1:0] req_ext;
   logic [1:0]             last_ext;
   logic [MAX_MASTERS-1:0] pick;
   logic                   unused_pick;

   always_comb begin
      req_ext              = '0;
      req_ext[N-1:0]       = req_i;
      last_ext             = '0;
      last_ext[IDX_W-1:0]  = last_grant_i;
      pick                 = rr_pick(req_ext, last_ext, N);
      grant_o              = enable_i ? pick[N-1:0] : '0;
      grant_idx_o          = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_o[i]) grant_idx_o = IDX_W'(i);
      end
   end

   assign unused_pick = ^pick;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin sharing of one single-port RAM between Avalon-MM masters
// Optional per-master grant counters built when ONCHIP_ARB_STATS_EN is defined.
module onchip_mem_arbiter
   import onchip_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
   input  logic [NUM_MASTERS-1:0]          m_read,
   input  logic [NUM_MASTERS-1:0]          m_write,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
   output logic [NUM_MASTERS-1:0]          m_waitrequest,
   output logic [DATA_W-1:0]               m_readdata,
   output logic [NUM_MASTERS-1:0]          m_readdatavalid,
   input  logic                            quiesce,
   output logic                            idle,
   output logic [ADDR_W-1:0]               mem_address,
   output logic [DATA_W/8-1:0]             mem_byteenable,
   output logic                            mem_chipselect,
   output logic                            mem_write,
   output logic [DATA_W-1:0]               mem_writedata,
   input  logic [DATA_W-1:0]               mem_readdata,
   input  logic                            stat_clr,
   output logic [NUM_MASTERS*STAT_W-1:0]   stat_grant_cnt
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDX_W-1:0]       grant_idx;
   logic                   grant_read;

   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic                   rd_vld_q, rd_vld_d;
   logic [IDX_W-1:0]       rd_id_q, rd_id_d;

   assign req = m_read | m_write;

   onchip_arb_rr_grant #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_grant (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .enable_i     (~quiesce & reset_n),
      .grant_o      (grant),
      .grant_idx_o  (grant_idx)
   );

   assign m_waitrequest  = req & ~grant;
   assign mem_chipselect = |grant;

   // Read+write together is a write, so it never produces readdatavalid.
   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_write      = 1'b0;
      grant_read     = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) begin
            mem_address    = m_address[i*ADDR_W +: ADDR_W];
            mem_byteenable = m_byteenable[i*BE_W +: BE_W];
            mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
            mem_write      = m_write[i];
            grant_read     = m_read[i] & ~m_write[i];
         end
      end
   end

   always_comb begin
      last_grant_d = mem_chipselect ? grant_idx : last_grant_q;
      rd_vld_d     = grant_read;
      rd_id_d      = grant_idx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= '0;
         rd_vld_q     <= 1'b0;
         rd_id_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_vld_q     <= rd_vld_d;
         rd_id_q      <= rd_id_d;
      end
   end

   always_comb begin
      m_readdatavalid          = '0;
      m_readdatavalid[rd_id_q] = rd_vld_q;
   end

   assign m_readdata = mem_readdata;
   assign idle       = ~mem_chipselect & ~rd_vld_q;

`ifdef ONCHIP_ARB_STATS_EN
   logic [NUM_MASTERS-1:0][STAT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (stat_clr)
            cnt_d[i] = '0;
         else if (grant[i] && (cnt_q[i] != {STAT_W{1'b1}}))
            cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign stat_grant_cnt = cnt_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - directed self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

   localparam int NM = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [31:0]   m_address;
   logic [7:0]    m_byteenable;
   logic [1:0]    m_read;
   logic [1:0]    m_write;
   logic [63:0]   m_writedata;
   logic [1:0]    m_waitrequest;
   logic [31:0]   m_readdata;
   logic [1:0]    m_readdatavalid;
   logic          quiesce;
   logic          idle;
   logic [15:0]   mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect;
   logic          mem_write;
   logic [31:0]   mem_writedata;
   logic [31:0]   mem_readdata;
   logic          stat_clr;
   logic [31:0]   stat_grant_cnt;

   logic [31:0]   ram [0:65535];
   int            n_tests = 0;
   int            n_fail  = 0;

   onchip_mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(16), .DATA_W(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .quiesce         (quiesce),
      .idle            (idle),
      .mem_address     (mem_address),
      .mem_byteenable  (mem_byteenable),
      .mem_chipselect  (mem_chipselect),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_readdata    (mem_readdata),
      .stat_clr        (stat_clr),
      .stat_grant_cnt  (stat_grant_cnt)
   );

   always #5 clk = ~clk;

   // Single-port RAM with 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n      = 1'b0;
      m_address    = '0;
      m_byteenable = '0;
      m_read       = '0;
      m_write      = '0;
      m_writedata  = '0;
      quiesce      = 1'b0;
      stat_clr     = 1'b0;
      cyc; cyc;
      #4;
      check("rst_idle",  64'(idle), 64'd1);
      check("rst_rdv",   64'(m_readdatavalid), 64'd0);
      check("rst_wreq",  64'(m_waitrequest), 64'd0);
      check("rst_cs",    64'(mem_chipselect), 64'd0);
      cyc;
      reset_n = 1'b1;

      // lone master 0: write then read-back on the next cycle
      m_write = 2'b01; m_address[15:0] = 16'h0010; m_byteenable[3:0] = 4'hF;
      m_writedata[31:0] = 32'hDEADBEEF;
      #4;
      check("t1_wr_wreq", 64'(m_waitrequest), 64'd0);
      check("t1_wr_cs",   64'({mem_chipselect, mem_write}), 64'b11);
      cyc;
      m_write = 2'b00; m_read = 2'b01;
      #4;
      check("t1_rd_wreq", 64'(m_waitrequest), 64'd0);
      check("t1_rd_rdv0", 64'(m_readdatavalid), 64'd0);
      cyc;
      m_read = 2'b00;
      #4;
      check("t1_rdv",  64'(m_readdatavalid), 64'b01);
      check("t1_data", 64'(m_readdata), 64'hDEADBEEF);

      // byte-enable merge
      cyc;
      m_write = 2'b01; m_address[15:0] = 16'h0020; m_byteenable[3:0] = 4'hF;
      m_writedata[31:0] = 32'h11223344;
      cyc;
      m_byteenable[3:0] = 4'h2; m_writedata[31:0] = 32'h0000AA00;
      cyc;
      m_write = 2'b00; m_read = 2'b01; m_byteenable[3:0] = 4'hF;
      cyc;
      m_read = 2'b00;
      #4;
      check("t3_rdv",  64'(m_readdatavalid), 64'b01);
      check("t3_data", 64'(m_readdata), 64'h1122AA44);

      // read+write together is a write: no readdatavalid
      cyc;
      m_read = 2'b01; m_write = 2'b01; m_address[15:0] = 16'h0030;
      m_writedata[31:0] = 32'h5;
      cyc;
      m_read = 2'b00; m_write = 2'b00;
      #4;
      check("rw_no_rdv", 64'(m_readdatavalid), 64'd0);

      // quiesce after an accepted read
      cyc;
      m_read = 2'b01; m_address[15:0] = 16'h0020;
      #4;
      check("q_acc_wreq", 64'(m_waitrequest), 64'd0);
      cyc;
      quiesce = 1'b1;
      #4;
      check("q_rdv",   64'(m_readdatavalid), 64'b01);
      check("q_data",  64'(m_readdata), 64'h1122AA44);
      check("q_wreq",  64'(m_waitrequest), 64'b01);
      check("q_cs",    64'(mem_chipselect), 64'd0);
      check("q_idle0", 64'(idle), 64'd0);
      cyc;
      #4;
      check("q_idle1", 64'(idle), 64'd1);
      check("q_rdv0",  64'(m_readdatavalid), 64'd0);
      quiesce = 1'b0;
      #1;
      check("q_resume_wreq", 64'(m_waitrequest), 64'd0);
      check("q_resume_cs",   64'(mem_chipselect), 64'd1);

      // reset right after an accepted read discards the return
      cyc;
      m_read = 2'b00;
      cyc;
      m_read = 2'b01; m_address[15:0] = 16'h0010;
      cyc;
      reset_n = 1'b0; m_read = 2'b00;
      #4;
      check("rst_mid_rdv",  64'(m_readdatavalid), 64'd0);
      check("rst_mid_idle", 64'(idle), 64'd1);
      cyc;
      reset_n = 1'b1;

      // both masters continuously reading: master 1 first, then alternate
      m_read = 2'b11; m_address = {16'h0020, 16'h0010};
      for (int k = 0; k < 6; k++) begin
         #4;
         check($sformatf("rr_wreq%0d", k), 64'(m_waitrequest), (k % 2 == 0) ? 64'b01 : 64'b10);
         if (k >= 1) begin
            check($sformatf("rr_rdv%0d", k), 64'(m_readdatavalid), (k % 2 == 1) ? 64'b10 : 64'b01);
            check($sformatf("rr_data%0d", k), 64'(m_readdata),
                  (k % 2 == 1) ? 64'h1122AA44 : 64'hDEADBEEF);
         end
         cyc;
      end
      m_read = 2'b00;

`ifdef ONCHIP_ARB_STATS_EN
      stat_clr = 1'b1;
      cyc;
      stat_clr = 1'b0; m_write = 2'b01; m_address = {16'h0040, 16'h0040};
      repeat (5) cyc;
      m_write = 2'b10;
      repeat (3) cyc;
      m_write = 2'b00;
      #4;
      check("st_cnt0", 64'(stat_grant_cnt[15:0]),  64'd5);
      check("st_cnt1", 64'(stat_grant_cnt[31:16]), 64'd3);
      cyc;
      stat_clr = 1'b1; m_write = 2'b01;
      cyc;
      stat_clr = 1'b0; m_write = 2'b00;
      #4;
      check("st_clr_win", 64'(stat_grant_cnt[15:0]), 64'd0);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      m_write = 2'b01;
      cyc;
      m_write = 2'b00;
      #4;
      check("st_sat", 64'(stat_grant_cnt[15:0]), 64'hFFFF);
`else
      #4;
      check("st_off_zero", 64'(stat_grant_cnt), 64'd0);
`endif

      cyc;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
